// File: rtl/alu16_arbiter_if.sv
// Bus bundle linking the two ALU requesters, the shared alu16 and the response consumer.
// The arbiter uses the slave modport; the requester/ALU/consumer side uses master.
interface alu16_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4
);
    logic             Req0_Valid;
    logic             Req0_Ready;
    logic [WIDTH-1:0] Req0_R;
    logic [WIDTH-1:0] Req0_S;
    logic [OP_W-1:0]  Req0_Op;

    logic             Req1_Valid;
    logic             Req1_Ready;
    logic [WIDTH-1:0] Req1_R;
    logic [WIDTH-1:0] Req1_S;
    logic [OP_W-1:0]  Req1_Op;

    logic [WIDTH-1:0] Alu_R;
    logic [WIDTH-1:0] Alu_S;
    logic [OP_W-1:0]  Alu_Op;
    logic [WIDTH-1:0] Alu_Y;
    logic             Alu_N;
    logic             Alu_Z;
    logic             Alu_C;

    logic             Rsp_Valid;
    logic             Rsp_Ready;
    logic             Rsp_Id;
    logic [WIDTH-1:0] Rsp_Y;
    logic             Rsp_N;
    logic             Rsp_Z;
    logic             Rsp_C;

    modport slave (
        input  Req0_Valid, Req0_R, Req0_S, Req0_Op,
        output Req0_Ready,
        input  Req1_Valid, Req1_R, Req1_S, Req1_Op,
        output Req1_Ready,
        output Alu_R, Alu_S, Alu_Op,
        input  Alu_Y, Alu_N, Alu_Z, Alu_C,
        output Rsp_Valid, Rsp_Id, Rsp_Y, Rsp_N, Rsp_Z, Rsp_C,
        input  Rsp_Ready
    );

    modport master (
        output Req0_Valid, Req0_R, Req0_S, Req0_Op,
        input  Req0_Ready,
        output Req1_Valid, Req1_R, Req1_S, Req1_Op,
        input  Req1_Ready,
        input  Alu_R, Alu_S, Alu_Op,
        output Alu_Y, Alu_N, Alu_Z, Alu_C,
        input  Rsp_Valid, Rsp_Id, Rsp_Y, Rsp_N, Rsp_Z, Rsp_C,
        output Rsp_Ready
    );
endinterface

// File: rtl/alu16_arbiter.sv
// Two-requester arbiter in front of one combinational alu16, one operation in flight.
// Define ALU_ARB_PERF_EN to add saturating per-requester grant counters.
module alu16_arbiter #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4,
    parameter int RR_EN = 1
) (
    input  logic clk,
    input  logic reset_n,
    alu16_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0] Grant_Cnt0,
    output logic [15:0] Grant_Cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             grant_id;
    logic             transfer;
    logic             last_id_q, last_id_d;
    logic [WIDTH-1:0] alu_r_q, alu_r_d;
    logic [WIDTH-1:0] alu_s_q, alu_s_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_n_q, rsp_n_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_c_q, rsp_c_d;

    // On contention round-robin favours whoever did not win last time.
    always_comb begin
        grant_id = 1'b0;
        if (bus.Req0_Valid && bus.Req1_Valid) begin
            grant_id = (RR_EN != 0) ? ~last_id_q : 1'b0;
        end else if (bus.Req1_Valid) begin
            grant_id = 1'b1;
        end
        transfer = reset_n && (state_q == IDLE) && (bus.Req0_Valid || bus.Req1_Valid);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (transfer) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.Rsp_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.Req0_Ready = transfer && !grant_id;
        bus.Req1_Ready = transfer && grant_id;
        bus.Rsp_Valid  = (state_q == RESP);
    end

    always_comb begin
        last_id_d = last_id_q;
        alu_r_d   = alu_r_q;
        alu_s_d   = alu_s_q;
        alu_op_d  = alu_op_q;
        rsp_id_d  = rsp_id_q;
        rsp_y_d   = rsp_y_q;
        rsp_n_d   = rsp_n_q;
        rsp_z_d   = rsp_z_q;
        rsp_c_d   = rsp_c_q;
        if (transfer) begin
            last_id_d = grant_id;
            alu_r_d   = grant_id ? bus.Req1_R  : bus.Req0_R;
            alu_s_d   = grant_id ? bus.Req1_S  : bus.Req0_S;
            alu_op_d  = grant_id ? bus.Req1_Op : bus.Req0_Op;
        end
        // The ALU has had a full cycle on the registered operands by the end of EXEC.
        if (state_q == EXEC) begin
            rsp_id_d = last_id_q;
            rsp_y_d  = bus.Alu_Y;
            rsp_n_d  = bus.Alu_N;
            rsp_z_d  = bus.Alu_Z;
            rsp_c_d  = bus.Alu_C;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_id_q <= 1'b1;
            alu_r_q   <= '0;
            alu_s_q   <= '0;
            alu_op_q  <= '0;
            rsp_id_q  <= 1'b0;
            rsp_y_q   <= '0;
            rsp_n_q   <= 1'b0;
            rsp_z_q   <= 1'b0;
            rsp_c_q   <= 1'b0;
        end else begin
            last_id_q <= last_id_d;
            alu_r_q   <= alu_r_d;
            alu_s_q   <= alu_s_d;
            alu_op_q  <= alu_op_d;
            rsp_id_q  <= rsp_id_d;
            rsp_y_q   <= rsp_y_d;
            rsp_n_q   <= rsp_n_d;
            rsp_z_q   <= rsp_z_d;
            rsp_c_q   <= rsp_c_d;
        end
    end

    assign bus.Alu_R  = alu_r_q;
    assign bus.Alu_S  = alu_s_q;
    assign bus.Alu_Op = alu_op_q;
    assign bus.Rsp_Id = rsp_id_q;
    assign bus.Rsp_Y  = rsp_y_q;
    assign bus.Rsp_N  = rsp_n_q;
    assign bus.Rsp_Z  = rsp_z_q;
    assign bus.Rsp_C  = rsp_c_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (transfer && !grant_id && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
        if (transfer && grant_id && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign Grant_Cnt0 = cnt0_q;
    assign Grant_Cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu16_arbiter.sv
// Drives a round-robin and a fixed-priority alu16_arbiter with identical directed stimulus
// and compares both against a transaction-level model every cycle.
module tb_alu16_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [15:0] r0 = '0, s0 = '0, r1 = '0, s1 = '0;
    logic [3:0]  op0 = '0, op1 = '0;
    logic        rsp_rdy = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu16_arbiter_if #(.WIDTH(16), .OP_W(4)) bus_rr ();
    alu16_arbiter_if #(.WIDTH(16), .OP_W(4)) bus_fp ();

    // Reference alu16: 0 pass S, 1 pass R, 2 add with carry, 3 AND, others XOR.
    function automatic logic [18:0] alu_ref(input logic [3:0] op, input logic [15:0] r,
                                            input logic [15:0] s);
        logic [16:0] sum;
        logic [15:0] y;
        logic        c;
        sum = {1'b0, r} + {1'b0, s};
        c = 1'b0;
        case (op)
            4'd0:    y = s;
            4'd1:    y = r;
            4'd2:    begin y = sum[15:0]; c = sum[16]; end
            4'd3:    y = r & s;
            default: y = r ^ s;
        endcase
        return {c, y[15], (y == 16'h0000), y};
    endfunction

    assign bus_rr.Req0_Valid = v0;
    assign bus_rr.Req0_R     = r0;
    assign bus_rr.Req0_S     = s0;
    assign bus_rr.Req0_Op    = op0;
    assign bus_rr.Req1_Valid = v1;
    assign bus_rr.Req1_R     = r1;
    assign bus_rr.Req1_S     = s1;
    assign bus_rr.Req1_Op    = op1;
    assign bus_rr.Rsp_Ready  = rsp_rdy;
    assign {bus_rr.Alu_C, bus_rr.Alu_N, bus_rr.Alu_Z, bus_rr.Alu_Y} =
        alu_ref(bus_rr.Alu_Op, bus_rr.Alu_R, bus_rr.Alu_S);

    assign bus_fp.Req0_Valid = v0;
    assign bus_fp.Req0_R     = r0;
    assign bus_fp.Req0_S     = s0;
    assign bus_fp.Req0_Op    = op0;
    assign bus_fp.Req1_Valid = v1;
    assign bus_fp.Req1_R     = r1;
    assign bus_fp.Req1_S     = s1;
    assign bus_fp.Req1_Op    = op1;
    assign bus_fp.Rsp_Ready  = rsp_rdy;
    assign {bus_fp.Alu_C, bus_fp.Alu_N, bus_fp.Alu_Z, bus_fp.Alu_Y} =
        alu_ref(bus_fp.Alu_Op, bus_fp.Alu_R, bus_fp.Alu_S);

`ifdef ALU_ARB_PERF_EN
    logic [15:0] cnt0_rr, cnt1_rr, cnt0_fp, cnt1_fp;
`endif

    alu16_arbiter #(.WIDTH(16), .OP_W(4), .RR_EN(1)) dut_rr (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_rr)
`ifdef ALU_ARB_PERF_EN
        ,
        .Grant_Cnt0(cnt0_rr),
        .Grant_Cnt1(cnt1_rr)
`endif
    );

    alu16_arbiter #(.WIDTH(16), .OP_W(4), .RR_EN(0)) dut_fp (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_fp)
`ifdef ALU_ARB_PERF_EN
        ,
        .Grant_Cnt0(cnt0_fp),
        .Grant_Cnt1(cnt1_fp)
`endif
    );

    // Model index 0 is the round-robin instance, 1 the fixed-priority instance.
    typedef struct {
        logic        exec;
        logic        rsp_valid;
        logic        last_id;
        logic [15:0] alu_r;
        logic [15:0] alu_s;
        logic [3:0]  alu_op;
        logic        rsp_id;
        logic [15:0] rsp_y;
        logic        rsp_n;
        logic        rsp_z;
        logic        rsp_c;
        int          cnt0;
        int          cnt1;
    } model_t;

    model_t m[2];
    bit     model_live = 1'b0;

    function automatic int winner(input int d);
        if (v0 && v1) return (d == 0) ? ((m[d].last_id == 1'b1) ? 0 : 1) : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic logic exp_ready(input int d, input int k);
        return reset_n && !m[d].exec && !m[d].rsp_valid && (winner(d) == k);
    endfunction

    task automatic model_step();
        int w;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                m[d].exec      = 1'b0;
                m[d].rsp_valid = 1'b0;
                m[d].last_id   = 1'b1;
                m[d].alu_r     = '0;
                m[d].alu_s     = '0;
                m[d].alu_op    = '0;
                m[d].rsp_id    = 1'b0;
                m[d].rsp_y     = '0;
                m[d].rsp_n     = 1'b0;
                m[d].rsp_z     = 1'b0;
                m[d].rsp_c     = 1'b0;
                m[d].cnt0      = 0;
                m[d].cnt1      = 0;
            end else if (m[d].rsp_valid) begin
                if (rsp_rdy) m[d].rsp_valid = 1'b0;
            end else if (m[d].exec) begin
                {m[d].rsp_c, m[d].rsp_n, m[d].rsp_z, m[d].rsp_y} =
                    alu_ref(m[d].alu_op, m[d].alu_r, m[d].alu_s);
                m[d].rsp_id    = m[d].last_id;
                m[d].rsp_valid = 1'b1;
                m[d].exec      = 1'b0;
            end else begin
                w = winner(d);
                if (w >= 0) begin
                    m[d].alu_r   = (w == 1) ? r1 : r0;
                    m[d].alu_s   = (w == 1) ? s1 : s0;
                    m[d].alu_op  = (w == 1) ? op1 : op0;
                    m[d].last_id = (w == 1);
                    m[d].exec    = 1'b1;
                    if (w == 0 && m[d].cnt0 < 65535) m[d].cnt0++;
                    if (w == 1 && m[d].cnt1 < 65535) m[d].cnt1++;
                end
            end
        end
        if (!reset_n) model_live = 1'b1;
    endtask

    task automatic checkField(input string name, input int d, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut=%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic checkDut(input int d, input logic rdy0, input logic rdy1,
                            input logic [15:0] ar, input logic [15:0] as, input logic [3:0] aop,
                            input logic rv, input logic rid, input logic [15:0] ry,
                            input logic rn, input logic rz, input logic rc);
        checkField("Req0_Ready", d, rdy0, exp_ready(d, 0));
        checkField("Req1_Ready", d, rdy1, exp_ready(d, 1));
        checkField("Alu_R", d, ar, m[d].alu_r);
        checkField("Alu_S", d, as, m[d].alu_s);
        checkField("Alu_Op", d, aop, m[d].alu_op);
        checkField("Rsp_Valid", d, rv, m[d].rsp_valid);
        checkField("Rsp_Id", d, rid, m[d].rsp_id);
        checkField("Rsp_Y", d, ry, m[d].rsp_y);
        checkField("Rsp_N", d, rn, m[d].rsp_n);
        checkField("Rsp_Z", d, rz, m[d].rsp_z);
        checkField("Rsp_C", d, rc, m[d].rsp_c);
    endtask

    task automatic checkOutput();
        if (!model_live) return;
        checkDut(0, bus_rr.Req0_Ready, bus_rr.Req1_Ready, bus_rr.Alu_R, bus_rr.Alu_S,
                 bus_rr.Alu_Op, bus_rr.Rsp_Valid, bus_rr.Rsp_Id, bus_rr.Rsp_Y,
                 bus_rr.Rsp_N, bus_rr.Rsp_Z, bus_rr.Rsp_C);
        checkDut(1, bus_fp.Req0_Ready, bus_fp.Req1_Ready, bus_fp.Alu_R, bus_fp.Alu_S,
                 bus_fp.Alu_Op, bus_fp.Rsp_Valid, bus_fp.Rsp_Id, bus_fp.Rsp_Y,
                 bus_fp.Rsp_N, bus_fp.Rsp_Z, bus_fp.Rsp_C);
`ifdef ALU_ARB_PERF_EN
        checkField("Grant_Cnt0", 0, {16'h0, cnt0_rr}, m[0].cnt0);
        checkField("Grant_Cnt1", 0, {16'h0, cnt1_rr}, m[0].cnt1);
        checkField("Grant_Cnt0", 1, {16'h0, cnt0_fp}, m[1].cnt0);
        checkField("Grant_Cnt1", 1, {16'h0, cnt1_fp}, m[1].cnt1);
`endif
    endtask

    // Compare mid-cycle once inputs have settled, then advance the model on the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            checkOutput();
            @(posedge clk);
            model_step();
        end
    end

    task automatic driveOnly(input logic iv0, input logic [15:0] ir0, input logic [15:0] is0,
                             input logic [3:0] iop0, input logic iv1, input logic [15:0] ir1,
                             input logic [15:0] is1, input logic [3:0] iop1,
                             input logic irdy, input logic irst);
        @(negedge clk);
        v0 = iv0; r0 = ir0; s0 = is0; op0 = iop0;
        v1 = iv1; r1 = ir1; s1 = is1; op1 = iop1;
        rsp_rdy = irdy;
        reset_n = irst;
    endtask

    task automatic applyStimulus(input logic iv0, input logic [15:0] ir0, input logic [15:0] is0,
                                 input logic [3:0] iop0, input logic iv1, input logic [15:0] ir1,
                                 input logic [15:0] is1, input logic [3:0] iop1,
                                 input logic irdy, input logic irst);
        driveOnly(iv0, ir0, is0, iop0, iv1, ir1, is1, iop1, irdy, irst);
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycle(input logic irdy, input logic irst);
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'h0, irdy, irst);
    endtask

    task automatic runOp(input int id, input logic [15:0] r, input logic [15:0] s,
                         input logic [3:0] op);
        if (id == 0) applyStimulus(1'b1, r, s, op, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
        else         applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, r, s, op, 1'b0, 1'b1);
        idleCycle(1'b0, 1'b1);
        idleCycle(1'b1, 1'b1);
    endtask

    logic        ids_rr[$], ids_fp[$];
    logic [15:0] ys_rr[$], ys_fp[$];
    logic        exp_id_rr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_y_rr[4]  = '{16'hCCCC, 16'hC3C3, 16'hCCCC, 16'hC3C3};

    initial begin
        $display("[TB] start");

        // Reset with random inputs on every pin.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                          1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                          1'($urandom), 1'b0);
        end
        checkField("reset_Req0_Ready", 0, bus_rr.Req0_Ready, 1'b0);
        checkField("reset_Req1_Ready", 0, bus_rr.Req1_Ready, 1'b0);
        checkField("reset_Rsp_Valid", 0, bus_rr.Rsp_Valid, 1'b0);
        checkField("reset_Alu_R", 0, bus_rr.Alu_R, 16'h0000);
        checkField("reset_Rsp_Y", 1, bus_fp.Rsp_Y, 16'h0000);

        // Requester 0 alone, pass S.
        driveOnly(1'b1, 16'hAA55, 16'h55AA, 4'd0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
        #2;
        checkField("t2_Req0_Ready_idle", 0, bus_rr.Req0_Ready, 1'b1);
        @(posedge clk);
        #2;
        idleCycle(1'b0, 1'b1);
        checkField("t2_Rsp_Valid", 0, bus_rr.Rsp_Valid, 1'b1);
        checkField("t2_Rsp_Id", 0, bus_rr.Rsp_Id, 1'b0);
        checkField("t2_Rsp_Y", 0, bus_rr.Rsp_Y, 16'h55AA);
        checkField("t2_Rsp_N", 0, bus_rr.Rsp_N, 1'b0);
        checkField("t2_Rsp_Z", 0, bus_rr.Rsp_Z, 1'b0);
        idleCycle(1'b1, 1'b1);

        // Both held valid for four operations, after a fresh reset.
        idleCycle(1'b0, 1'b0);
        idleCycle(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 16'hCCCC, 16'h3333, 4'd1, 1'b1, 16'hC3C3, 16'h3C3C, 4'd1,
                          1'b1, 1'b1);
            if (bus_rr.Rsp_Valid) begin
                ids_rr.push_back(bus_rr.Rsp_Id);
                ys_rr.push_back(bus_rr.Rsp_Y);
            end
            if (bus_fp.Rsp_Valid) begin
                ids_fp.push_back(bus_fp.Rsp_Id);
                ys_fp.push_back(bus_fp.Rsp_Y);
            end
        end
        checkField("t3_rr_count", 0, ids_rr.size(), 4);
        checkField("t3_fp_count", 1, ids_fp.size(), 4);
        for (int i = 0; i < 4 && i < ids_rr.size(); i++) begin
            checkField("t3_rr_grant", 0, ids_rr[i], exp_id_rr[i]);
            checkField("t3_rr_y", 0, ys_rr[i], exp_y_rr[i]);
        end
        for (int i = 0; i < 4 && i < ids_fp.size(); i++) begin
            checkField("t3_fp_grant", 1, ids_fp[i], 1'b0);
            checkField("t3_fp_y", 1, ys_fp[i], 16'hCCCC);
        end

        // Consumer stalls the response for five cycles; FFFF + 0001 sets Z and C.
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 16'hFFFF, 16'h0001, 4'd2, 1'b0, 1'b1);
        idleCycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h1234, 16'h4321, 4'd3, 1'b1, 16'h5678, 16'h8765, 4'd4,
                          1'b0, 1'b1);
            checkField("t4_Rsp_Valid", 0, bus_rr.Rsp_Valid, 1'b1);
            checkField("t4_Rsp_Y", 0, bus_rr.Rsp_Y, 16'h0000);
            checkField("t4_Rsp_C", 0, bus_rr.Rsp_C, 1'b1);
            checkField("t4_Rsp_Z", 0, bus_rr.Rsp_Z, 1'b1);
            checkField("t4_Rsp_Id", 1, bus_fp.Rsp_Id, 1'b1);
            checkField("t4_Req0_Ready", 0, bus_rr.Req0_Ready, 1'b0);
            checkField("t4_Req1_Ready", 1, bus_fp.Req1_Ready, 1'b0);
        end
        idleCycle(1'b1, 1'b1);
        checkField("t4_Rsp_Valid_after", 0, bus_rr.Rsp_Valid, 1'b0);

        // Reset lands while a requester 1 operation is executing.
        applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 16'hF0F0, 16'hFF00, 4'd3, 1'b0, 1'b1);
        idleCycle(1'b1, 1'b0);
        checkField("t5_Rsp_Valid", 0, bus_rr.Rsp_Valid, 1'b0);
        checkField("t5_Rsp_Y", 0, bus_rr.Rsp_Y, 16'h0000);
        applyStimulus(1'b1, 16'h1111, 16'h2222, 4'd4, 1'b1, 16'h3333, 16'h4444, 4'd4,
                      1'b1, 1'b1);
        checkField("t5_first_grant_R", 0, bus_rr.Alu_R, 16'h1111);
        checkField("t5_first_grant_R", 1, bus_fp.Alu_R, 16'h1111);
        idleCycle(1'b1, 1'b1);
        checkField("t5_Rsp_Id", 0, bus_rr.Rsp_Id, 1'b0);
        checkField("t5_Rsp_Y", 0, bus_rr.Rsp_Y, 16'h3333);
        idleCycle(1'b1, 1'b1);

        // Three requester 0 operations then one requester 1 operation.
        idleCycle(1'b0, 1'b0);
        runOp(0, 16'h7FFF, 16'h0001, 4'd2);
        runOp(0, 16'hFF0F, 16'h0FF0, 4'd3);
        runOp(0, 16'hA5A5, 16'hA5A5, 4'd5);
        runOp(1, 16'h8001, 16'h8001, 4'd2);
`ifdef ALU_ARB_PERF_EN
        checkField("t6_Grant_Cnt0", 0, {16'h0, cnt0_rr}, 32'd3);
        checkField("t6_Grant_Cnt1", 0, {16'h0, cnt1_rr}, 32'd1);
        checkField("t6_Grant_Cnt0", 1, {16'h0, cnt0_fp}, 32'd3);
        checkField("t6_Grant_Cnt1", 1, {16'h0, cnt1_fp}, 32'd1);
`endif
        idleCycle(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
